// File: rtl/teclado7_antirrebote.sv
`default_nettype none
// ============================================================================
// Module   : teclado7_antirrebote
// Brief    : 7-key synchronizer, debouncer and n-key-lockout capture stage
//            feeding a one-hot vector to the 7-to-3 encoder.
//            Optional macro TECLADO_RETENER_EN: X keeps the last key on release.
// Revision : 1.0
// ============================================================================
module teclado7_antirrebote #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Teclas,
    output logic [6:0] X,
    output logic       Nueva,
    output logic       Ocupado
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESSED      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    logic [6:0] w_stable;
    logic [2:0] w_top;
    state_t     r_state;
    logic [2:0] r_key;

    for (genvar i = 0; i < 7; i++) begin : g_bit
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_d;
        logic                   w_s;

        assign w_s         = r_sync[SYNC_STAGES-1];
        assign w_stable[i] = r_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_d    <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], Teclas[i]};
                // A level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
                if (w_s == r_d) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_CNT_MAX) begin
                    r_d   <= w_s;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_top = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (w_stable[i]) begin
                w_top = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_key   <= 3'd0;
            X       <= 7'd0;
            Nueva   <= 1'b0;
            Ocupado <= 1'b0;
        end else begin
            Nueva <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_stable != 7'd0) begin
                        r_key   <= w_top;
                        X       <= 7'd1 << w_top;
                        Nueva   <= 1'b1;
                        Ocupado <= 1'b1;
                        r_state <= PRESSED;
                    end
                end
                PRESSED: begin
                    // Only the captured key matters; others are locked out
                    if (!w_stable[r_key]) begin
`ifndef TECLADO_RETENER_EN
                        X <= 7'd0;
`endif
                        if (w_stable == 7'd0) begin
                            Ocupado <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= WAIT_RELEASE;
                        end
                    end
                end
                WAIT_RELEASE: begin
                    if (w_stable == 7'd0) begin
                        Ocupado <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    Ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
